// File: rtl/jk_universal_shift_reg.sv
// jk_universal_shift_reg
//   Parametrised parallel-access shift register with J/K serial entry,
//   bidirectional shift, rotate and an autonomous burst-shift controller.
//
// Ports:
//   CP          clock, rising edge
//   MR          asynchronous active-high master reset
//   S[1:0]      mode: 00 hold, 01 shift up, 10 shift down, 11 parallel load
//   P           parallel load data
//   J, KN       J/K-bar serial entry to Q[0] on shift up
//   DSL         serial entry to Q[LENGTH-1] on shift down
//   ROT         rotate instead of serial entry
//   BURST_START request a burst of BURST_CNT shifts in direction S
//   BURST_CNT   number of shifts in the burst
//   Q           register contents
//   QMSB_N      ~Q[LENGTH-1] (combinational)
//   BUSY        burst in progress
//   DONE        one-cycle pulse when a burst (or degenerate request) completes
module jk_universal_shift_reg #(
  parameter int unsigned LENGTH = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              CP,
  input  logic              MR,
  input  logic [1:0]        S,
  input  logic [LENGTH-1:0] P,
  input  logic              J,
  input  logic              KN,
  input  logic              DSL,
  input  logic              ROT,
  input  logic              BURST_START,
  input  logic [CNT_W-1:0]  BURST_CNT,
  output logic [LENGTH-1:0] Q,
  output logic              QMSB_N,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t            r_state, w_state_nxt;
  logic [LENGTH-1:0] r_q, w_q_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_dir, w_dir_nxt;
  logic              r_done, w_done_nxt;

  logic              w_up_in;
  logic              w_down_in;
  logic [LENGTH-1:0] w_q_up;
  logic [LENGTH-1:0] w_q_down;

  // Serial entry bits; J/K entry follows Q0n = (J & ~Q0) | (KN & Q0)
  assign w_up_in   = ROT ? r_q[LENGTH-1] : ((J & ~r_q[0]) | (KN & r_q[0]));
  assign w_down_in = ROT ? r_q[0] : DSL;
  assign w_q_up    = {r_q[LENGTH-2:0], w_up_in};
  assign w_q_down  = {w_down_in, r_q[LENGTH-1:1]};

  // State register
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= MODE_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state: burst sequencing takes priority over the S operation
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_BURST: begin
        w_q_nxt   = (r_dir == MODE_DOWN) ? w_q_down : w_q_up;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        if (BURST_START) begin
          // Start edge never shifts or loads; bad requests just pulse DONE
          if (((S == MODE_UP) || (S == MODE_DOWN)) && (BURST_CNT != '0)) begin
            w_state_nxt = ST_BURST;
            w_cnt_nxt   = BURST_CNT;
            w_dir_nxt   = S;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          unique case (S)
            MODE_UP:   w_q_nxt = w_q_up;
            MODE_DOWN: w_q_nxt = w_q_down;
            MODE_LOAD: w_q_nxt = P;
            default:   w_q_nxt = r_q;
          endcase
        end
      end
    endcase
  end

  assign Q      = r_q;
  assign QMSB_N = ~r_q[LENGTH-1];
  assign BUSY   = (r_state == ST_BURST);
  assign DONE   = r_done;

endmodule
